// File: rtl/nibble_pkg.sv
// Shared widths and state encoding for the nibble serializer.
package nibble_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/word_buf.sv
// One-entry input buffer: takes a word on valid/ready, releases it on load.
module word_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load,
  output logic [WIDTH-1:0] buf_data,
  output logic             buf_valid
);

  // Ready only when empty and out of reset; a load never coincides with a transfer.
  assign in_ready = rst_n && !buf_valid;

  // Buffer register: fill on transfer, drain on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      buf_data  <= in_data;
      buf_valid <= 1'b1;
    end else if (load) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Serializes NIBBLES x 4-bit words into a nibble stream, LSB nibble first.
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        pause,
  output logic [NIBBLE_W-1:0]         out_nibble,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [CNT_W-1:0]            word_count
);

  localparam int unsigned WORD_W = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  ser_state_e          state_q, state_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load;
  logic [WORD_W-1:0]   buf_data;
  logic                buf_valid;
  logic                is_last;

  word_buf #(
    .WIDTH(WORD_W)
  ) u_word_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load     (load),
    .buf_data (buf_data),
    .buf_valid(buf_valid)
  );

  // State, shift register, nibble index and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: shift while unpaused, count on the last nibble, reload from the buffer.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    is_last = (idx_q == IDX_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (buf_valid) load = 1'b1;
      end
      ST_SHIFT: begin
        if (!pause) begin
          if (is_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (buf_valid) load = 1'b1;
            else           state_d = ST_IDLE;
          end else begin
            sr_d  = sr_q >> NIBBLE_W;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load restarts the word regardless of where it came from.
    if (load) begin
      sr_d    = buf_data;
      idx_d   = '0;
      state_d = ST_SHIFT;
    end
  end

  // Output strobe follows pause combinationally; data and count come from registers.
  always_comb begin
    out_nibble = sr_q[NIBBLE_W-1:0];
    out_valid  = (state_q == ST_SHIFT) && !pause;
    out_last   = out_valid && (idx_q == IDX_LAST);
    word_count = cnt_q;
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Randomized self-checking bench for nibble_serializer (NIBBLES = 4).
module tb_nibble_serializer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         pause;
  logic [3:0]   out_nibble;
  logic         out_valid;
  logic         out_last;
  logic [7:0]   word_count;

  nibble_serializer #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pause     (pause),
    .out_nibble(out_nibble),
    .out_valid (out_valid),
    .out_last  (out_last),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] acc_q[$];
  logic [4:0]   obs_q[$];
  int           obs_cyc[$];
  logic [4:0]   exp_q[$];

  logic       o_valid, o_last, o_ready, last_acc;
  logic [3:0] o_nib;

  // Reference: every accepted word becomes NIB nibbles, LSB first, last flagged.
  function automatic void build_expected();
    logic [W-1:0] w;
    logic [3:0]   n;
    exp_q.delete();
    foreach (acc_q[k]) begin
      for (int i = 0; i < NIB; i++) begin
        w = acc_q[k] >> (4 * i);
        n = w[3:0];
        exp_q.push_back({(i == NIB - 1), n});
      end
    end
  endfunction

  function automatic void clear_logs();
    acc_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    cyc = 0;
  endfunction

  // One clock: drive inputs, sample outputs mid-cycle, log transfers and nibbles.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    pause    = p;
    #1;
    o_valid  = out_valid;
    o_last   = out_last;
    o_nib    = out_nibble;
    o_ready  = in_ready;
    last_acc = v && in_ready;
    if (last_acc) acc_q.push_back(d);
    if (out_valid) begin
      obs_q.push_back({out_last, out_nibble});
      obs_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output logic timed_out);
    int n;
    n = 0;
    do begin
      drive_cycle(1'b0, '0, 1'b0);
      n++;
    end while ((obs_q.size() < acc_q.size() * NIB || o_valid) && n < 300);
    timed_out = (n >= 300);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    total++; if (out_nibble !== 4'h0) begin bad++; $display("FAIL reset_out_nibble: got %h want 0", out_nibble); end
    total++; if (word_count !== 8'd0) begin bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_release: got %b want 1", in_ready); end
    clear_logs();
  endtask

  task automatic test_single();
    int exp_cyc[4] = '{2, 3, 4, 5};
    clear_logs();
    drive_cycle(1'b1, 16'h4321, 1'b0);
    for (int k = 1; k <= 6; k++) drive_cycle(1'b0, '0, 1'b0);
    build_expected();
    total++; if (acc_q.size() != 1) begin bad++; $display("FAIL single_accept: got %0d want 1", acc_q.size()); end
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL single_len: got %0d want 4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != exp_cyc[i]) begin bad++; $display("FAIL single_timing[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", o_valid); end
    total++; if (word_count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", word_count); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3] = '{16'hFFFF, 16'h0001, 16'h1000};
    int wi, n, sum;
    logic [7:0] wc0;
    clear_logs();
    wc0 = word_count;
    wi = 0; n = 0;
    do begin
      if (wi < 3) begin
        drive_cycle(1'b1, words[wi], 1'b0);
        if (last_acc) wi++;
      end else drive_cycle(1'b0, '0, 1'b0);
      n++;
    end while (!(wi == 3 && obs_q.size() >= 12 && !o_valid) && n < 40);
    total++; if (n >= 40) begin bad++; $display("FAIL b2b_timeout: got %0d cycles want <40", n); end
    build_expected();
    sum = 0;
    foreach (obs_q[i]) sum += int'(obs_q[i][3:0]);
    total++;
    if (obs_q.size() != 12) begin bad++; $display("FAIL b2b_len: got %0d want 12", obs_q.size()); end
    else begin
      total++; if (obs_cyc[11] - obs_cyc[0] != 11) begin bad++; $display("FAIL b2b_gapless: got span %0d want 11", obs_cyc[11] - obs_cyc[0]); end
      foreach (exp_q[i]) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    total++; if (sum != 62) begin bad++; $display("FAIL b2b_sum: got %0d want 62", sum); end
    total++; if (8'(word_count - wc0) !== 8'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", 8'(word_count - wc0)); end
  endtask

  task automatic test_pause();
    int exp_cyc[4] = '{2, 6, 7, 8};
    clear_logs();
    drive_cycle(1'b1, 16'hABCD, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, '0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pause_valid[%0d]: got %b want 0", k, o_valid); end
      total++; if (o_nib !== 4'hC) begin bad++; $display("FAIL pause_hold[%0d]: got %h want c", k, o_nib); end
    end
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, '0, 1'b0);
    build_expected();
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL pause_len: got %0d want 4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL pause_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != exp_cyc[i]) begin bad++; $display("FAIL pause_timing[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words[5];
    int wi, n, stalls;
    logic prev, tmo;
    logic [7:0] wc0;
    foreach (words[i]) words[i] = W'($urandom);
    clear_logs();
    wc0 = word_count;
    wi = 0; n = 0; stalls = 0; prev = 1'b0;
    while (wi < 5 && n < 60) begin
      drive_cycle(1'b1, words[wi], 1'b0);
      if (!o_ready) stalls++;
      if (prev) begin
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_full_after_xfer: got %b want 0", o_ready); end
      end
      prev = last_acc;
      if (last_acc) wi++;
      n++;
    end
    drain(tmo);
    total++; if (tmo || wi != 5) begin bad++; $display("FAIL bp_timeout: got %0d words want 5", wi); end
    total++; if (stalls == 0) begin bad++; $display("FAIL bp_stall: got %0d stalls want >0", stalls); end
    total++;
    if (acc_q.size() != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", acc_q.size()); end
    else foreach (words[i]) begin
      total++; if (acc_q[i] !== words[i]) begin bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, acc_q[i], words[i]); end
    end
    build_expected();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (8'(word_count - wc0) !== 8'd5) begin bad++; $display("FAIL bp_count: got %0d want 5", 8'(word_count - wc0)); end
  endtask

  task automatic test_random();
    logic v, p, prev, tmo;
    logic [7:0] wc0;
    clear_logs();
    wc0 = word_count;
    prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) == 0);
      drive_cycle(v, W'($urandom), p);
      if (prev) begin
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rnd_full_after_xfer[%0d]: got %b want 0", i, o_ready); end
      end
      if (p) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rnd_pause_valid[%0d]: got %b want 0", i, o_valid); end
      end
      prev = last_acc;
    end
    drain(tmo);
    total++; if (tmo) begin bad++; $display("FAIL rnd_timeout: got %0d nibbles want %0d", obs_q.size(), acc_q.size() * NIB); end
    build_expected();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (8'(word_count - wc0) !== 8'(acc_q.size())) begin bad++; $display("FAIL rnd_count: got %0d want %0d", 8'(word_count - wc0), 8'(acc_q.size())); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    drive_cycle(1'b1, 16'h8765, 1'b0);
    n = 0;
    do begin
      drive_cycle(1'b1, 16'h1111, 1'b0);
      n++;
    end while (!last_acc && n < 10);
    while (obs_q.size() < 3 && n < 20) begin
      drive_cycle(1'b0, '0, 1'b0);
      n++;
    end
    total++; if (acc_q.size() != 2) begin bad++; $display("FAIL rmid_buffered: got %0d words want 2", acc_q.size()); end
    total++;
    if (obs_q.size() != 3) begin bad++; $display("FAIL rmid_pre_len: got %0d want 3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (obs_q[i] !== 5'(i + 5)) begin bad++; $display("FAIL rmid_pre[%0d]: got %h want %h", i, obs_q[i], 5'(i + 5)); end
    end
    rst_n = 1'b0;
    drive_cycle(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    total++; if (word_count !== 8'd0) begin bad++; $display("FAIL rmid_count: got %0d want 0", word_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    obs_q.delete();
    for (int k = 0; k < 12; k++) drive_cycle(1'b0, '0, 1'b0);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_silent: got %0d nibbles want 0", obs_q.size()); end
    total++; if (word_count !== 8'd0) begin bad++; $display("FAIL rmid_count_after: got %0d want 0", word_count); end
  endtask

  task automatic test_wrap();
    int n, pulses;
    logic nonzero, tmo;
    logic [7:0] wc0;
    clear_logs();
    wc0 = word_count;
    n = 0; nonzero = 1'b0;
    while (acc_q.size() < 256 && n < 1300) begin
      drive_cycle(1'b1, '0, 1'b0);
      if (word_count != wc0) nonzero = 1'b1;
      n++;
    end
    drain(tmo);
    pulses = 0;
    foreach (obs_q[i]) if (obs_q[i][4]) pulses++;
    total++; if (tmo || acc_q.size() != 256) begin bad++; $display("FAIL wrap_timeout: got %0d words want 256", acc_q.size()); end
    total++; if (pulses != 256) begin bad++; $display("FAIL wrap_last_pulses: got %0d want 256", pulses); end
    total++; if (obs_q.size() != 1024) begin bad++; $display("FAIL wrap_len: got %0d want 1024", obs_q.size()); end
    total++; if (!nonzero) begin bad++; $display("FAIL wrap_moving: got stuck count %0d want change", word_count); end
    total++; if (word_count !== wc0) begin bad++; $display("FAIL wrap_count: got %0d want %0d", word_count, wc0); end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    pause    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
